// File: rtl/sysfiltr_ram_arbiter.sv
// ---------------------------------------------------------------------------
// sysfiltr_ram_arbiter
//
// Shares one port of the SysFiltr on-chip RAM (2**ADDR_W x DATA_W) between two
// Avalon-MM masters, M0 and M1, with round-robin arbitration and fixed-length
// bursts. The command path is purely combinational: a granted master sees
// waitrequest=0 in the cycle it presents its command, and its command is on
// ram_* in that same cycle. The RAM registers its address, so read data comes
// back one cycle after issue. A 1-bit valid/owner pair steers readdatavalid to
// the right master.
//
// Handshake: a master command or write beat is transferred on a rising clock
// edge where the master holds read or write high and its waitrequest is 0.
// readdatavalid is a one-cycle qualifier with no back-pressure.
//
// Ports
//   clk, reset_n           clock; asynchronous active-low reset
//   mX_address/read/write/byteenable/writedata/burstcount
//                          master X command (X = 0, 1)
//   mX_waitrequest         1 = command or beat not accepted this cycle
//   mX_readdata            ram_readdata, broadcast to both masters
//   mX_readdatavalid       readdata belongs to master X this cycle
//   ram_address/chipselect/write/byteenable/writedata/clken
//                          RAM port controls
//   ram_readdata           RAM q, valid one cycle after a read address
//   dbg_state              current arbiter FSM state (0 idle, 1 rburst, 2 wburst)
// ---------------------------------------------------------------------------
module sysfiltr_ram_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 32,
  parameter int BE_W    = 4,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,

  input  logic [ADDR_W-1:0]  m0_address,
  input  logic               m0_read,
  input  logic               m0_write,
  input  logic [BE_W-1:0]    m0_byteenable,
  input  logic [DATA_W-1:0]  m0_writedata,
  input  logic [BURST_W-1:0] m0_burstcount,
  output logic               m0_waitrequest,
  output logic [DATA_W-1:0]  m0_readdata,
  output logic               m0_readdatavalid,

  input  logic [ADDR_W-1:0]  m1_address,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [BE_W-1:0]    m1_byteenable,
  input  logic [DATA_W-1:0]  m1_writedata,
  input  logic [BURST_W-1:0] m1_burstcount,
  output logic               m1_waitrequest,
  output logic [DATA_W-1:0]  m1_readdata,
  output logic               m1_readdatavalid,

  output logic [ADDR_W-1:0]  ram_address,
  output logic               ram_chipselect,
  output logic               ram_write,
  output logic [BE_W-1:0]    ram_byteenable,
  output logic [DATA_W-1:0]  ram_writedata,
  output logic               ram_clken,
  input  logic [DATA_W-1:0]  ram_readdata,

  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RBURST = 2'd1,
    ST_WBURST = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0]  ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] BC_ONE   = {{(BURST_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic                 last_q, last_d;     // master granted most recently
  logic                 own_q, own_d;       // burst owner
  logic [ADDR_W-1:0]    base_q, base_d;     // next burst beat address
  logic [BURST_W-1:0]   rem_q, rem_d;       // beats still to go in the burst
  logic                 rv_q, rv_d;         // a read was issued last cycle
  logic                 ro_q, ro_d;         // which master that read belongs to

  logic                 req0, req1;
  logic                 sel_idle;
  logic                 sel;
  logic [ADDR_W-1:0]    s_address;
  logic                 s_write;
  logic [BE_W-1:0]      s_byteenable;
  logic [DATA_W-1:0]    s_writedata;
  logic [BURST_W-1:0]   s_burstcount;
  logic [BURST_W-1:0]   bc_eff;

  logic                 wr0, wr1;
  logic [ADDR_W-1:0]    c_address;
  logic                 c_chipselect;
  logic                 c_write;
  logic [BE_W-1:0]      c_byteenable;
  logic [DATA_W-1:0]    c_writedata;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Contended grant goes to the master that did not win last time; otherwise
  // the sole requester (req1 alone selects M1, anything else selects M0).
  assign sel_idle = (req0 && req1) ? ~last_q : req1;

  // Outside IDLE the burst owner is locked onto the shared command mux.
  assign sel = (state_q == ST_IDLE) ? sel_idle : own_q;

  assign s_address    = sel ? m1_address    : m0_address;
  assign s_write      = sel ? m1_write      : m0_write;
  assign s_byteenable = sel ? m1_byteenable : m0_byteenable;
  assign s_writedata  = sel ? m1_writedata  : m0_writedata;
  assign s_burstcount = sel ? m1_burstcount : m0_burstcount;

  // A burstcount of 0 behaves as a single access.
  assign bc_eff = (s_burstcount == '0) ? BC_ONE : s_burstcount;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    own_d        = own_q;
    base_d       = base_q;
    rem_d        = rem_q;
    rv_d         = 1'b0;
    ro_d         = ro_q;
    wr0          = 1'b1;
    wr1          = 1'b1;
    c_address    = '0;
    c_chipselect = 1'b0;
    c_write      = 1'b0;
    c_byteenable = '0;
    c_writedata  = '0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          if (sel) wr1 = 1'b0;
          else     wr0 = 1'b0;
          last_d       = sel;
          c_chipselect = 1'b1;
          c_address    = s_address;
          c_write      = s_write;
          c_byteenable = s_byteenable;
          c_writedata  = s_writedata;
          // Write has priority when a master raises both read and write.
          if (!s_write) begin
            rv_d = 1'b1;
            ro_d = sel;
          end
          if (bc_eff > BC_ONE) begin
            own_d   = sel;
            base_d  = s_address + ADDR_ONE;
            rem_d   = bc_eff - BC_ONE;
            state_d = s_write ? ST_WBURST : ST_RBURST;
          end
        end
      end

      ST_RBURST: begin
        // The arbiter generates the remaining read addresses itself; both
        // masters are held off until the burst is done.
        c_chipselect = 1'b1;
        c_address    = base_q;
        rv_d         = 1'b1;
        ro_d         = own_q;
        base_d       = base_q + ADDR_ONE;
        rem_d        = rem_q - BC_ONE;
        if (rem_q <= BC_ONE) state_d = ST_IDLE;
      end

      ST_WBURST: begin
        if (own_q) wr1 = 1'b0;
        else       wr0 = 1'b0;
        // A deasserted write is a stall: nothing reaches the RAM and the
        // beat counters hold. A read raised by the owner here is ignored.
        if (s_write) begin
          c_chipselect = 1'b1;
          c_write      = 1'b1;
          c_address    = base_q;
          c_byteenable = s_byteenable;
          c_writedata  = s_writedata;
          base_d       = base_q + ADDR_ONE;
          rem_d        = rem_q - BC_ONE;
          if (rem_q <= BC_ONE) state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      base_q  <= '0;
      rem_q   <= '0;
      rv_q    <= 1'b0;
      ro_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      base_q  <= base_d;
      rem_q   <= rem_d;
      rv_q    <= rv_d;
      ro_q    <= ro_d;
    end
  end

  // The command path is combinational, so while reset is held the outputs are
  // forced to their idle values instead of following the incoming requests.
  assign m0_waitrequest   = wr0 | ~reset_n;
  assign m1_waitrequest   = wr1 | ~reset_n;
  assign ram_chipselect   = c_chipselect & reset_n;
  assign ram_write        = c_write & reset_n;
  assign ram_address      = reset_n ? c_address    : '0;
  assign ram_byteenable   = reset_n ? c_byteenable : '0;
  assign ram_writedata    = reset_n ? c_writedata  : '0;
  assign ram_clken        = 1'b1;

  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign m0_readdatavalid = rv_q & ~ro_q;
  assign m1_readdatavalid = rv_q & ro_q;

  assign dbg_state        = state_q;

endmodule

// File: tb/tb_sysfiltr_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sysfiltr_ram_arbiter
//
// Directed bench for the two-master RAM arbiter. Includes a behavioural RAM
// with a registered read address and unregistered q. Inputs are driven 1 ns
// after the rising edge and outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_sysfiltr_ram_arbiter;

  logic        clk;
  logic        reset_n;

  logic [14:0] m0_address, m1_address;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_burstcount, m1_burstcount;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;

  logic [14:0] ram_address;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata, ram_readdata;
  logic [1:0]  dbg_state;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  sysfiltr_ram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_burstcount(m0_burstcount), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_burstcount(m1_burstcount), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_byteenable(ram_byteenable),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [31:0] mem [0:32767];
  logic [14:0] raddr = '0;
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        raddr <= ram_address;
      end
    end
  end
  assign ram_readdata = mem[raddr];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic init_inputs();
    clear_inputs();
    m0_address = '0; m1_address = '0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = '0; m1_writedata = '0;
    m0_burstcount = 4'd1; m1_burstcount = 4'd1;
  endtask

  // Single uncontended write through M0; the command is taken at the next edge.
  task automatic m0_single_write(input logic [14:0] a, input logic [31:0] d);
    tick();
    clear_inputs();
    m0_write = 1; m0_address = a; m0_writedata = d; m0_byteenable = 4'hF; m0_burstcount = 4'd1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 0;
    m0_read = 1; m1_write = 1;
    tick();
    #1;
    checks++; if (m0_waitrequest !== 1'b1) begin failures++; $display("FAIL reset_m0_wait got=%0h exp=1", m0_waitrequest); end
    checks++; if (m1_waitrequest !== 1'b1) begin failures++; $display("FAIL reset_m1_wait got=%0h exp=1", m1_waitrequest); end
    checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin failures++; $display("FAIL reset_rdv got=%0b exp=00", {m0_readdatavalid, m1_readdatavalid}); end
    checks++; if ({ram_chipselect, ram_write} !== 2'b00) begin failures++; $display("FAIL reset_ram_ctl got=%0b exp=00", {ram_chipselect, ram_write}); end
    checks++; if (ram_clken !== 1'b1) begin failures++; $display("FAIL reset_clken got=%0h exp=1", ram_clken); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    clear_inputs();
    tick();
    reset_n = 1;
  endtask

  task automatic test_single();
    tick();
    m0_write = 1; m0_address = 15'h0010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF; m0_burstcount = 4'd1;
    #1;
    checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin failures++; $display("FAIL single_wr_wait got=%0b exp=01", {m0_waitrequest, m1_waitrequest}); end
    checks++; if ({ram_chipselect, ram_write, ram_address} !== {2'b11, 15'h0010}) begin failures++; $display("FAIL single_wr_cmd got=%0b/%0b/%h exp=1/1/0010", ram_chipselect, ram_write, ram_address); end
    checks++; if (ram_writedata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_wr_data got=%h exp=deadbeef", ram_writedata); end
    tick();
    m0_write = 0; m0_read = 1; m0_burstcount = 4'd0;
    #1;
    checks++; if ({m0_waitrequest, ram_chipselect, ram_write} !== 3'b010) begin failures++; $display("FAIL single_rd_cmd got=%0b exp=010", {m0_waitrequest, ram_chipselect, ram_write}); end
    tick();
    m0_read = 0;
    #1;
    checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10) begin failures++; $display("FAIL single_rdv got=%0b exp=10", {m0_readdatavalid, m1_readdatavalid}); end
    checks++; if (m0_readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_rdata got=%h exp=deadbeef", m0_readdata); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL single_bc0_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_contention();
    logic g0, pg0;
    logic [31:0] exp_d;
    int n0, n1;
    m0_single_write(15'h0020, 32'hCAFEF00D);
    tick();
    clear_inputs();
    apply_reset();
    n0 = 0; n1 = 0; pg0 = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      tick();
      m0_read = 1; m0_address = 15'h0010; m0_burstcount = 4'd1;
      m1_read = 1; m1_address = 15'h0020; m1_burstcount = 4'd1;
      #1;
      g0 = (k % 2 == 0);
      checks++; if ({m0_waitrequest, m1_waitrequest} !== {~g0, g0}) begin failures++; $display("FAIL contend_grant k=%0d got=%0b exp=%0b", k, {m0_waitrequest, m1_waitrequest}, {~g0, g0}); end
      if (k > 0) begin
        exp_d = exp_q.pop_front();
        checks++; if ({m0_readdatavalid, m1_readdatavalid} !== {pg0, ~pg0}) begin failures++; $display("FAIL contend_rdv k=%0d got=%0b exp=%0b", k, {m0_readdatavalid, m1_readdatavalid}, {pg0, ~pg0}); end
        checks++; if (m0_readdata !== exp_d) begin failures++; $display("FAIL contend_rdata k=%0d got=%h exp=%h", k, m0_readdata, exp_d); end
      end
      if (m0_readdatavalid) n0++;
      if (m1_readdatavalid) n1++;
      exp_q.push_back(g0 ? 32'hDEADBEEF : 32'hCAFEF00D);
      pg0 = g0;
    end
    tick();
    clear_inputs();
    #1;
    exp_d = exp_q.pop_front();
    checks++; if ({m1_readdatavalid, m1_readdata} !== {1'b1, exp_d}) begin failures++; $display("FAIL contend_last got=%0b/%h exp=1/%h", m1_readdatavalid, m1_readdata, exp_d); end
    if (m1_readdatavalid) n1++;
    checks++; if (n0 != 3 || n1 != 3) begin failures++; $display("FAIL contend_counts got=%0d/%0d exp=3/3", n0, n1); end
  endtask

  task automatic test_read_burst();
    logic [14:0] a;
    a = 15'h7FFC;
    for (int k = 0; k < 8; k++) begin
      m0_single_write(a, 32'hB000_0000 | k);
      a = a + 15'd1;
    end
    // last grant went to M0, so M1 wins the contended burst request
    tick();
    clear_inputs();
    m0_read = 1; m0_address = 15'h0010; m0_burstcount = 4'd1;
    m1_read = 1; m1_address = 15'h7FFC; m1_burstcount = 4'd8;
    #1;
    checks++; if ({m0_waitrequest, m1_waitrequest, ram_address} !== {2'b10, 15'h7FFC}) begin failures++; $display("FAIL rburst_start got=%0b/%h exp=10/7ffc", {m0_waitrequest, m1_waitrequest}, ram_address); end
    a = 15'h7FFC;
    for (int k = 1; k < 8; k++) begin
      tick();
      m1_read = 0;
      #1;
      a = a + 15'd1;
      checks++; if ({m0_waitrequest, m1_waitrequest, ram_chipselect, ram_write, ram_address} !== {4'b1110, a}) begin failures++; $display("FAIL rburst_beat k=%0d got=%0b/%h exp=1110/%h", k, {m0_waitrequest, m1_waitrequest, ram_chipselect, ram_write}, ram_address, a); end
      checks++; if ({m1_readdatavalid, m0_readdatavalid, m1_readdata} !== {2'b10, 32'hB000_0000 | (k - 1)}) begin failures++; $display("FAIL rburst_rdata k=%0d got=%0b/%h exp=10/%h", k, {m1_readdatavalid, m0_readdatavalid}, m1_readdata, 32'hB000_0000 | (k - 1)); end
    end
    tick();
    #1;
    checks++; if ({m0_waitrequest, ram_address, dbg_state} !== {1'b0, 15'h0010, 2'd0}) begin failures++; $display("FAIL rburst_m0_after got=%0b/%h/%0d exp=0/0010/0", m0_waitrequest, ram_address, dbg_state); end
    checks++; if ({m1_readdatavalid, m1_readdata} !== {1'b1, 32'hB000_0007}) begin failures++; $display("FAIL rburst_lastdata got=%0b/%h exp=1/b0000007", m1_readdatavalid, m1_readdata); end
    tick();
    clear_inputs();
    #1;
    checks++; if ({m0_readdatavalid, m1_readdatavalid, m0_readdata} !== {2'b10, 32'hDEADBEEF}) begin failures++; $display("FAIL rburst_m0_data got=%0b/%h exp=10/deadbeef", {m0_readdatavalid, m1_readdatavalid}, m0_readdata); end
  endtask

  task automatic test_write_burst_stall();
    tick();
    m0_write = 1; m0_address = 15'h0100; m0_writedata = 32'h4000_0000; m0_byteenable = 4'hF; m0_burstcount = 4'd4;
    #1;
    checks++; if ({m0_waitrequest, ram_write, ram_address} !== {2'b01, 15'h0100}) begin failures++; $display("FAIL wburst_b0 got=%0b/%h exp=01/0100", {m0_waitrequest, ram_write}, ram_address); end
    tick();
    m0_address = 15'h03FF; m0_writedata = 32'h4000_0001;
    m1_write = 1; m1_address = 15'h0200; m1_writedata = 32'h2222_2222; m1_burstcount = 4'd1;
    #1;
    checks++; if ({m0_waitrequest, m1_waitrequest, ram_write, ram_address, dbg_state} !== {3'b011, 15'h0101, 2'd2}) begin failures++; $display("FAIL wburst_b1 got=%0b/%h/%0d exp=011/0101/2", {m0_waitrequest, m1_waitrequest, ram_write}, ram_address, dbg_state); end
    for (int k = 0; k < 3; k++) begin
      tick();
      m0_write = 0; m0_read = 1;
      #1;
      checks++; if ({m0_waitrequest, m1_waitrequest, ram_chipselect, ram_write, dbg_state} !== {4'b0100, 2'd2}) begin failures++; $display("FAIL wburst_stall k=%0d got=%0b/%0d exp=0100/2", k, {m0_waitrequest, m1_waitrequest, ram_chipselect, ram_write}, dbg_state); end
    end
    tick();
    m0_read = 0; m0_write = 1; m0_writedata = 32'h4000_0002;
    #1;
    checks++; if ({ram_write, ram_address, ram_writedata} !== {1'b1, 15'h0102, 32'h4000_0002}) begin failures++; $display("FAIL wburst_b2 got=%0b/%h/%h exp=1/0102/40000002", ram_write, ram_address, ram_writedata); end
    tick();
    m0_writedata = 32'h4000_0003;
    #1;
    checks++; if ({m1_waitrequest, ram_write, ram_address} !== {2'b11, 15'h0103}) begin failures++; $display("FAIL wburst_b3 got=%0b/%h exp=11/0103", {m1_waitrequest, ram_write}, ram_address); end
    tick();
    m0_write = 0;
    #1;
    checks++; if ({m1_waitrequest, ram_address, dbg_state} !== {1'b0, 15'h0200, 2'd0}) begin failures++; $display("FAIL wburst_release got=%0b/%h/%0d exp=0/0200/0", m1_waitrequest, ram_address, dbg_state); end
    tick();
    clear_inputs();
    m0_read = 1; m0_address = 15'h0100; m0_burstcount = 4'd4;
    #1;
    for (int k = 1; k < 5; k++) begin
      tick();
      m0_read = 0;
      #1;
      checks++; if ({m0_readdatavalid, m0_readdata} !== {1'b1, 32'h4000_0000 | (k - 1)}) begin failures++; $display("FAIL wburst_readback k=%0d got=%0b/%h exp=1/%h", k, m0_readdatavalid, m0_readdata, 32'h4000_0000 | (k - 1)); end
    end
  endtask

  task automatic test_byteenable();
    tick();
    m0_write = 1; m0_address = 15'h0300; m0_writedata = 32'h1122_3344; m0_byteenable = 4'hF; m0_burstcount = 4'd1;
    tick();
    m0_writedata = 32'hAABB_CCDD; m0_byteenable = 4'h5;
    #1;
    checks++; if ({m0_waitrequest, ram_byteenable} !== {1'b0, 4'h5}) begin failures++; $display("FAIL be_cmd got=%0b/%h exp=0/5", m0_waitrequest, ram_byteenable); end
    tick();
    m0_write = 0; m0_read = 1; m0_byteenable = 4'hF;
    tick();
    m0_read = 0;
    #1;
    checks++; if ({m0_readdatavalid, m0_readdata} !== {1'b1, 32'h11BB_33DD}) begin failures++; $display("FAIL be_merge got=%0b/%h exp=1/11bb33dd", m0_readdatavalid, m0_readdata); end
  endtask

  task automatic test_illegal_burst();
    int n;
    tick();
    m1_read = 1; m1_address = 15'h0500; m1_burstcount = 4'd10;
    n = 0;
    tick();
    clear_inputs();
    #1;
    while (dbg_state == 2'd1 && n < 20) begin
      n++;
      tick();
      #1;
    end
    checks++; if (n != 9 || dbg_state !== 2'd0) begin failures++; $display("FAIL illegal_bc10 got=%0d cycles state=%0d exp=9 cycles state=0", n, dbg_state); end
  endtask

  task automatic test_reset_mid_burst();
    tick();
    m0_read = 1; m0_address = 15'h0400; m0_burstcount = 4'd8;
    #1;
    checks++; if (m0_waitrequest !== 1'b0) begin failures++; $display("FAIL rstmid_grant got=%0b exp=0", m0_waitrequest); end
    tick();
    m0_read = 0;
    tick();
    #1;
    checks++; if ({m0_readdatavalid, dbg_state} !== {1'b1, 2'd1}) begin failures++; $display("FAIL rstmid_inburst got=%0b/%0d exp=1/1", m0_readdatavalid, dbg_state); end
    reset_n = 0;
    m0_read = 1; m1_read = 1; m0_address = 15'h0010; m1_address = 15'h0020; m0_burstcount = 4'd1; m1_burstcount = 4'd1;
    #1;
    checks++; if ({m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest, ram_chipselect} !== 5'b00110) begin failures++; $display("FAIL rstmid_outputs got=%0b exp=00110", {m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest, ram_chipselect}); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rstmid_state got=%0d exp=0", dbg_state); end
    tick();
    reset_n = 1;
    #1;
    checks++; if ({m0_waitrequest, m1_waitrequest, ram_address} !== {2'b01, 15'h0010}) begin failures++; $display("FAIL rstmid_first_grant got=%0b/%h exp=01/0010", {m0_waitrequest, m1_waitrequest}, ram_address); end
    tick();
    clear_inputs();
    #1;
    checks++; if ({m0_readdatavalid, m1_readdatavalid, m0_readdata} !== {2'b10, 32'hDEADBEEF}) begin failures++; $display("FAIL rstmid_rdata got=%0b/%h exp=10/deadbeef", {m0_readdatavalid, m1_readdatavalid}, m0_readdata); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    failures = 0;
    reset_n = 0;
    init_inputs();
    test_reset();
    test_single();
    test_contention();
    test_read_burst();
    test_write_burst_stall();
    test_byteenable();
    test_illegal_burst();
    test_reset_mid_burst();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
